// File: rtl/pe_psum_acc.sv
// Partial-sum accumulator behind the pe_acc reduction tree: sums beats up to in_last, holds the result.
// Optional macro PE_PSUM_SAT_EN selects signed saturating accumulation with a sticky overflow flag.
module pe_psum_acc #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_psum,
  input  logic              in_last,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_result,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_ovf
);

  typedef enum logic {ST_ACC = 1'b0, ST_OUT = 1'b1} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf;
  logic [DATA_W-1:0]   r_out_result;
  logic [CNT_W-1:0]    r_out_cnt;
  logic                r_out_ovf;

  logic                w_first;
  logic                w_accept;
  logic                w_consume;
  logic [DATA_W-1:0]   w_base;
  logic [DATA_W-1:0]   w_sum;
  logic                w_clamp;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_ovf_next;

  // A zero beat count marks the first-beat condition, so the first beat adds onto zero.
  assign w_first   = (r_cnt == '0);
  assign w_base    = w_first ? '0 : r_acc;
  assign in_rdy    = (r_state == ST_ACC) || out_rdy;
  assign w_accept  = in_vld && in_rdy;
  assign w_consume = (r_state == ST_OUT) && out_rdy;

`ifdef PE_PSUM_SAT_EN
  logic [DATA_W:0] w_wide;
  assign w_wide  = {w_base[DATA_W-1], w_base} + {in_psum[DATA_W-1], in_psum};
  assign w_clamp = w_wide[DATA_W] ^ w_wide[DATA_W-1];
  assign w_sum   = !w_clamp ? w_wide[DATA_W-1:0] :
                   (w_wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}});
`else
  assign w_clamp = 1'b0;
  assign w_sum   = w_base + in_psum;
`endif

  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_ovf_next = r_ovf | w_clamp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_ACC;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      r_out_result <= '0;
      r_out_cnt    <= '0;
      r_out_ovf    <= 1'b0;
    end else begin
      if (w_consume) begin
        r_state <= ST_ACC;
      end
      // clr discards the vector in progress (and any beat arriving with it) but never a held result.
      if (clr) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (w_accept) begin
        if (in_last) begin
          r_state      <= ST_OUT;
          r_out_result <= w_sum;
          r_out_cnt    <= w_cnt_inc;
          r_out_ovf    <= w_ovf_next;
          r_acc        <= '0;
          r_cnt        <= '0;
          r_ovf        <= 1'b0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= w_cnt_inc;
          r_ovf <= w_ovf_next;
        end
      end
    end
  end

  assign out_vld    = (r_state == ST_OUT);
  assign out_result = r_out_result;
  assign out_cnt    = r_out_cnt;
  assign out_ovf    = r_out_ovf;

endmodule

// File: tb/tb_pe_psum_acc.sv
// Scoreboard bench for pe_psum_acc: a vector-level reference model pushes expected results,
// a negedge monitor pops and compares whenever the DUT hands a result over.
module tb_pe_psum_acc;
  localparam int DW      = 32;
  localparam int CW      = 4;
  localparam int CNT_MAX = 15;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst, clr, in_vld, in_rdy, in_last, out_vld, out_rdy, out_ovf;
  logic [DW-1:0] in_psum, out_result;
  logic [CW-1:0] out_cnt;

  always #5 clk = ~clk;

  pe_psum_acc #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_psum(in_psum), .in_last(in_last), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_result(out_result), .out_cnt(out_cnt), .out_ovf(out_ovf)
  );

  typedef struct {
    logic [DW-1:0] res;
    logic [CW-1:0] cnt;
    logic          ovf;
  } exp_t;

  exp_t exp_q[$];
  int   beats[$];
  bit   m_full = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: sum the whole vector with plain integer arithmetic, applying the configured overflow rule.
  function automatic exp_t ref_vec(input int b[$]);
    exp_t   r;
    longint a;
    bit     o;
    int     n;
    a = 0;
    o = 1'b0;
    foreach (b[i]) begin
      if (i == 0) a = b[i];
      else begin
        a = a + longint'(b[i]);
`ifdef PE_PSUM_SAT_EN
        if (a > MAXV) begin a = MAXV; o = 1'b1; end
        else if (a < MINV) begin a = MINV; o = 1'b1; end
`else
        a = longint'(int'(a));
`endif
      end
    end
    n     = b.size();
    r.res = a[DW-1:0];
    r.cnt = (n > CNT_MAX) ? CW'(CNT_MAX) : CW'(n);
    r.ovf = o;
    return r;
  endfunction

  // Model: one update per rising edge, using the inputs driven during the previous cycle.
  initial begin
    bit rdy;
    forever begin
      @(posedge clk);
      rdy = !m_full || out_rdy;
      if (rst) begin
        m_full = 1'b0;
        beats.delete();
        exp_q.delete();
      end else begin
        if (m_full && out_rdy) m_full = 1'b0;
        if (clr) beats.delete();
        else if (in_vld && rdy) begin
          beats.push_back(int'(in_psum));
          if (in_last) begin
            exp_q.push_back(ref_vec(beats));
            beats.delete();
            m_full = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: handshake-level checks plus result comparison against the scoreboard.
  logic          hold = 1'b0;
  logic [DW-1:0] snap_res;
  logic [CW-1:0] snap_cnt;
  logic          snap_ovf;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("out_vld", 64'(out_vld), 64'(m_full));
      chk("in_rdy", 64'(in_rdy), 64'(!m_full || out_rdy));
      if (hold && out_vld) begin
        chk("hold_result", 64'(out_result), 64'(snap_res));
        chk("hold_cnt", 64'(out_cnt), 64'(snap_cnt));
        chk("hold_ovf", 64'(out_ovf), 64'(snap_ovf));
      end
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got 0x%0h expected none", out_result);
        end else begin
          e = exp_q.pop_front();
          chk("result", 64'(out_result), 64'(e.res));
          chk("cnt", 64'(out_cnt), 64'(e.cnt));
          chk("ovf", 64'(out_ovf), 64'(e.ovf));
        end
      end
      hold     = out_vld && !out_rdy;
      snap_res = out_result;
      snap_cnt = out_cnt;
      snap_ovf = out_ovf;
    end
  end

  task automatic cyc(input bit v, input int p, input bit l, input bit c, input bit r);
    in_vld  = v;
    in_psum = p;
    in_last = l;
    clr     = c;
    out_rdy = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    rst = 1'b1; clr = 1'b0; in_vld = 1'b0; in_psum = '0; in_last = 1'b0; out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_cnt", 64'(out_cnt), 64'd0);
    chk("rst_ovf", 64'(out_ovf), 64'd0);
    rst = 1'b0;

    // 5 + 7 + -2
    cyc(1, 5, 0, 0, 1); cyc(1, 7, 0, 0, 1); cyc(1, -2, 1, 0, 1);
    chk("s1_vld", 64'(out_vld), 64'd1);
    chk("s1_result", 64'(out_result), 64'd10);
    chk("s1_cnt", 64'(out_cnt), 64'd3);
    chk("s1_ovf", 64'(out_ovf), 64'd0);
    cyc(0, 0, 0, 0, 1);

    cyc(1, 32'h12345678, 1, 0, 1);
    chk("s2_result", 64'(out_result), 64'h12345678);
    chk("s2_cnt", 64'(out_cnt), 64'd1);
    cyc(0, 0, 0, 0, 1);

    // Backpressure: result held four cycles, pending beat admitted on release.
    cyc(1, 11, 1, 0, 0);
    repeat (4) begin
      cyc(1, 22, 1, 0, 0);
      chk("s3_in_rdy", 64'(in_rdy), 64'd0);
      chk("s3_held", 64'(out_result), 64'd11);
    end
    cyc(1, 22, 1, 0, 1);
    chk("s3_vld", 64'(out_vld), 64'd1);
    chk("s3_result", 64'(out_result), 64'd22);
    cyc(0, 0, 0, 0, 1);

    cyc(1, 32'h7FFFFFF0, 0, 0, 1); cyc(1, 32'h20, 1, 0, 1);
`ifdef PE_PSUM_SAT_EN
    chk("s4_result", 64'(out_result), 64'h7FFFFFFF);
    chk("s4_ovf", 64'(out_ovf), 64'd1);
`else
    chk("s4_result", 64'(out_result), 64'h80000010);
    chk("s4_ovf", 64'(out_ovf), 64'd0);
`endif
    cyc(0, 0, 0, 0, 1);

    cyc(1, 3, 0, 0, 1); cyc(1, 4, 0, 0, 1); cyc(1, 9, 1, 1, 1);
    chk("s5_clr_vld", 64'(out_vld), 64'd0);
    cyc(1, 1, 1, 0, 1);
    chk("s5_result", 64'(out_result), 64'd1);
    chk("s5_cnt", 64'(out_cnt), 64'd1);
    cyc(0, 0, 0, 0, 1);

    cyc(1, 42, 1, 0, 0); cyc(0, 0, 0, 0, 0);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
    chk("s6_vld", 64'(out_vld), 64'd0);
    chk("s6_result", 64'(out_result), 64'd0);
    cyc(1, 6, 1, 0, 1);
    chk("s6b_result", 64'(out_result), 64'd6);
    chk("s6b_cnt", 64'(out_cnt), 64'd1);
    cyc(0, 0, 0, 0, 1);

    // Counter saturation: 20 beats with a 4-bit counter.
    repeat (19) cyc(1, 1, 0, 0, 1);
    cyc(1, 1, 1, 0, 1);
    chk("s7_result", 64'(out_result), 64'd20);
    chk("s7_cnt", 64'(out_cnt), 64'd15);
    cyc(0, 0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: k = int'($urandom_range(0, 200)) - 100;
        1: k = int'($urandom);
        2: k = 32'h7FFFFF00 + int'($urandom_range(0, 255));
        default: k = 32'h80000000 + int'($urandom_range(0, 255));
      endcase
      rst = ($urandom_range(0, 199) == 0);
      cyc($urandom_range(0, 3) != 0, k, $urandom_range(0, 5) == 0,
          $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0);
    end
    rst = 1'b0;
    repeat (5) cyc(0, 0, 0, 0, 1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pe_psum_acc.md
PE_PSUM_ACC -- requirements
Module: pe_psum_acc

Interface
REQ-001 Parameter: DATA_W, default 32, width of each incoming partial sum and of the result (two's complement signed).
REQ-002 Parameter: CNT_W, default 16, width of the beat counter.
REQ-003 clk  input  1  clock; all logic is on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 clr  input  1  synchronous abort: discards the partial accumulation in progress.
REQ-006 in_vld  input  1  the partial sum on in_psum is valid.
REQ-007 in_rdy  output  1  the block can accept a beat this cycle.
REQ-008 in_psum  input  DATA_W  one partial sum, driven directly by the pe_acc reduction tree output.
REQ-009 in_last  input  1  the current beat is the final beat of the vector.
REQ-010 out_vld  output  1  the result is valid.
REQ-011 out_rdy  input  1  the consumer accepts the result.
REQ-012 out_result  output  DATA_W  the accumulated sum of the vector.
REQ-013 out_cnt  output  CNT_W  the number of beats accumulated into out_result.
REQ-014 out_ovf  output  1  sticky signed-overflow flag for the vector.

Function
REQ-015 Input handshake: a beat is accepted in a cycle where in_vld=1 and in_rdy=1.
REQ-016 Output handshake: the result is consumed in a cycle where out_vld=1 and out_rdy=1.
REQ-017 in_rdy shall equal (!out_vld || out_rdy); it is combinational and does not depend on in_vld.
REQ-018 The block has two states: ACC (collecting beats, out_vld=0) and OUT (result held, out_vld=1).
- ACC -> OUT: when a beat with in_last=1 is accepted.
- OUT -> ACC: when the result is consumed and no beat with in_last=1 is accepted in the same cycle.
- OUT -> OUT: when the result is consumed and a beat with in_last=1 is accepted in the same cycle.
REQ-019 Accumulator: the first accepted beat of a vector loads acc=in_psum; each later beat sets acc=acc+in_psum; the beat counter tracks the beat count the same way.
REQ-020 On accepting a beat with in_last=1:
- out_result, out_cnt and out_ovf are registered with the final values, including that beat.
- The accumulator, counter and overflow flag return to the first-beat condition.
- Latency is 1 cycle: out_vld rises on the edge that accepts the last beat.
REQ-021 A single-beat vector (in_last=1 on the first beat) gives out_result=in_psum, out_cnt=1.
REQ-022 In OUT, while the result has not been consumed, out_result, out_cnt and out_ovf stay stable and in_rdy=0.
REQ-023 In OUT with out_rdy=1, an accepted beat with in_last=0 starts the next vector's accumulation in that same cycle.
REQ-024 The beat counter saturates at 2^CNT_W-1 and does not wrap.
REQ-025 clr=1 returns the accumulator, counter and overflow flag to the first-beat condition.
- If a beat is accepted in the same cycle, clr wins and the beat is discarded, including one with in_last=1.
- clr does not affect a result already held in OUT.
REQ-026 in_psum, in_last and in_vld are ignored while in_rdy=0.

Reset
REQ-027 While rst=1, on each clock edge:
- out_vld=0, out_result=0, out_cnt=0, out_ovf=0.
- The accumulator and counter return to the first-beat condition.
- The state is ACC.
REQ-028 rst has priority over clr and over both handshakes; a reset in mid-vector or in OUT discards all data.
REQ-029 During rst=1, in_rdy follows REQ-017, and any beat it admits is discarded.

Configuration
REQ-030 Macro PE_PSUM_SAT_EN enables saturating accumulation.
REQ-031 With PE_PSUM_SAT_EN defined:
- Each addition is signed and clamps to 2^(DATA_W-1)-1 or -2^(DATA_W-1).
- out_ovf is set if any addition in the vector clamped.
REQ-032 Without PE_PSUM_SAT_EN:
- Additions wrap modulo 2^DATA_W.
- out_ovf is constant 0.

Verification
REQ-033 Scenario: beats 5, 7, -2 (last), out_rdy=1 -> one cycle after the last beat, out_vld=1, out_result=10, out_cnt=3, out_ovf=0.
REQ-034 Scenario: one beat 0x12345678 with in_last=1 -> out_result=0x12345678, out_cnt=1.
REQ-035 Scenario: out_rdy=0 for 4 cycles with out_vld=1 and in_vld=1 -> in_rdy=0, outputs held stable; on out_rdy=1 the pending beat is accepted in the same cycle.
REQ-036 Scenario: beats 0x7FFFFFF0, 0x20 (last) -> with PE_PSUM_SAT_EN: out_result=0x7FFFFFFF, out_ovf=1; without it: out_result=0x80000010, out_ovf=0.
REQ-037 Scenario: beats 3, 4, then clr=1 together with beat 9 (last), then beat 1 (last) -> a single result out_result=1, out_cnt=1.
REQ-038 Scenario: rst=1 for one cycle while in OUT holding 42 -> out_vld=0 next cycle; the next vector 6 (last) gives out_result=6, out_cnt=1.
